// File: rtl/ped_pkg.sv
// ped_pkg: shared types, vehicle-light codes and the legality check for the crossing controller.
package ped_pkg;
  typedef enum logic [2:0] {IDLE, WAITING, WALK, FLASH, CLEAR} state_t;
  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_REDAMB = 3'b110;
  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_AMBER  = 3'b010;
  function automatic logic legal_code(input logic [2:0] l);
    return l inside {L_RED, L_REDAMB, L_GREEN, L_AMBER};
  endfunction
endpackage

// File: rtl/ped_crossing_phase_timer.sv
// phase_timer: loadable down-counter that times the walk and flash phases.
//   clk, rst (async active-low), load/load_val (load has priority), en (decrement), zero (count is 0).
module phase_timer
  import ped_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  // The count holds at zero so an idle timer never wraps.
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/ped_crossing.sv
// ped_crossing: pedestrian crossing controller downstream of the vehicle light sequencer.
//   clk, rst (async active-low); red/amber/green vehicle lamps; button request level;
//   walk, dont_walk, wait_lamp lamps; err sticky illegal-code flag; served completed-walk count.
module ped_crossing
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             button,
  output logic             walk,
  output logic             dont_walk,
  output logic             wait_lamp,
  output logic             err,
  output logic [CNT_W-1:0] served
);
  state_t           state_q, state_d;
  logic             latch_q, latch_d, walk_q, walk_d, dw_q, dw_d, err_q, err_d;
  logic [CNT_W-1:0] served_q, served_d;
  logic [2:0]       l;
  logic             legal, is_red, zero, load;
  logic [7:0]       load_val;
  assign l      = {red, amber, green};
  assign legal  = legal_code(l);
  assign is_red = l == L_RED;
  phase_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (state_q == WALK || state_q == FLASH),
    .zero     (zero)
  );
  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    load     = 1'b0;
    load_val = 8'(WALK_CYCLES - 1);
    // An illegal light code overrides every other transition.
    if (!legal) state_d = CLEAR;
    else
      case (state_q)
        IDLE:    if (latch_q) state_d = WAITING;
        WAITING: if (is_red) begin
          state_d = WALK;
          load    = 1'b1;
        end
        WALK: if (!is_red) state_d = CLEAR;
        else if (zero) begin
          state_d  = FLASH;
          load     = 1'b1;
          load_val = 8'(FLASH_CYCLES - 1);
        end
        // Losing red ends the crossing early; only a complete flash counts as served.
        FLASH: if (!is_red) state_d = CLEAR;
        else if (zero) begin
          state_d  = CLEAR;
          served_d = served_q + 1'b1;
        end
        CLEAR:   if (!is_red) state_d = latch_q ? WAITING : IDLE;
        default: state_d = CLEAR;
      endcase
    // A press on the very edge that enters WALK is kept as a fresh request for the next red phase.
    latch_d = button | (latch_q & ~(state_d == WALK && state_q != WALK));
    err_d   = err_q | ~legal;
    walk_d  = state_d == WALK;
    dw_d    = state_d == WALK ? 1'b0 : (state_d == FLASH && state_q == FLASH) ? ~dw_q : 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      latch_q  <= 1'b0;
      walk_q   <= 1'b0;
      dw_q     <= 1'b1;
      err_q    <= 1'b0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      latch_q  <= latch_d;
      walk_q   <= walk_d;
      dw_q     <= dw_d;
      err_q    <= err_d;
      served_q <= served_d;
    end
  assign walk      = walk_q;
  assign dont_walk = dw_q;
  assign wait_lamp = latch_q;
  assign err       = err_q;
  assign served    = served_q;
endmodule

// File: tb/tb_ped_crossing.sv
// tb_ped_crossing: randomized and directed checks of ped_crossing against a phase/elapsed-time model.
module tb_ped_crossing;
  localparam int WALK_CYCLES = 8, FLASH_CYCLES = 4;
  localparam int P_IDLE = 0, P_WAIT = 1, P_WALK = 2, P_FLASH = 3, P_CLEAR = 4;
  logic clk = 1'b0, rst = 1'b0, red = 1'b1, amber = 1'b0, green = 1'b0, button = 1'b0;
  logic walk, dont_walk, wait_lamp, err, walk_w, dont_walk_w, wait_w, err_w;
  logic [7:0] served;
  logic [1:0] served_w;
  wire  [17:0] got = {walk, dont_walk, wait_lamp, err, served, walk_w, dont_walk_w, wait_w, err_w, served_w};
  int checks = 0, failures = 0;
  int m_ph, m_el, m_served;
  logic m_req, m_err;

  ped_crossing dut (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green), .button(button),
    .walk(walk), .dont_walk(dont_walk), .wait_lamp(wait_lamp), .err(err), .served(served)
  );
  ped_crossing #(.CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green), .button(button),
    .walk(walk_w), .dont_walk(dont_walk_w), .wait_lamp(wait_w), .err(err_w), .served(served_w)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph = P_IDLE; m_el = 0; m_served = 0; m_req = 1'b0; m_err = 1'b0;
  endtask

  function automatic logic [17:0] exp_vec();
    logic w, d;
    w = m_ph == P_WALK;
    d = m_ph == P_FLASH ? (m_el % 2 == 0) : !w;
    return {w, d, m_req, m_err, 8'(m_served), w, d, m_req, m_err, 2'(m_served)};
  endfunction

  // Advance one clock: the model applies the crossing rules to the inputs seen at the edge.
  task automatic tick();
    logic [2:0] l;
    logic lg, rd, nreq;
    int np, nel, ns;
    l = {red, amber, green};
    lg = l inside {3'b100, 3'b110, 3'b001, 3'b010};
    rd = l == 3'b100;
    np = m_ph; nel = m_el + 1; ns = m_served; nreq = m_req | button;
    if (!lg) np = P_CLEAR;
    else if (m_ph == P_IDLE) begin if (m_req) np = P_WAIT; end
    else if (m_ph == P_WAIT) begin if (rd) begin np = P_WALK; nel = 0; end end
    else if (m_ph == P_WALK) begin
      if (!rd) np = P_CLEAR;
      else if (m_el == WALK_CYCLES - 1) begin np = P_FLASH; nel = 0; end
    end else if (m_ph == P_FLASH) begin
      if (!rd) np = P_CLEAR;
      else if (m_el == FLASH_CYCLES - 1) begin np = P_CLEAR; ns = m_served + 1; end
    end else if (!rd) np = m_req ? P_WAIT : P_IDLE;
    if (np == P_WALK && m_ph != P_WALK) nreq = button;
    @(posedge clk); #1;
    if (!rst) model_reset();
    else begin
      m_ph = np; m_el = nel; m_served = ns; m_req = nreq; m_err = m_err | !lg;
    end
  endtask

  task automatic set_l(input logic [2:0] l);
    {red, amber, green} = l;
  endtask

  task automatic do_reset();
    rst = 1'b0; set_l(3'b100); button = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic request();
    set_l(3'b001); button = 1'b1;
    tick();
    button = 1'b0; set_l(3'b100);
  endtask

  task automatic test_reset();
    rst = 1'b0; set_l(3'b100); button = 1'b0;
    repeat (3) tick();
    checks++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", got, exp_vec());
    end
    rst = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (got !== exp_vec() || walk !== 1'b0 || wait_lamp !== 1'b0) begin
        failures++; $display("FAIL reset_idle got=%h exp=%h", got, exp_vec());
      end
    end
  endtask

  task automatic test_full_service();
    int wcnt = 0;
    logic [3:0] pat = '0;
    int npat = 0;
    bit seen = 0;
    do_reset();
    request();
    checks++;
    if (wait_lamp !== 1'b1 || got !== exp_vec()) begin
      failures++; $display("FAIL full_wait_set got=%h exp=%h", got, exp_vec());
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL full_model cycle=%0d got=%h exp=%h", i, got, exp_vec());
      end
      if (!seen && !walk) begin
        checks++;
        if (wait_lamp !== 1'b1) begin
          failures++; $display("FAIL full_wait_hold cycle=%0d got=%b exp=1", i, wait_lamp);
        end
      end
      if (walk) begin wcnt++; seen = 1; end
      else if (seen && npat < 4) begin pat = {pat[2:0], dont_walk}; npat++; end
    end
    checks++;
    if (wcnt != WALK_CYCLES) begin
      failures++; $display("FAIL full_walk_len got=%0d exp=%0d", wcnt, WALK_CYCLES);
    end
    checks++;
    if (pat !== 4'b1010) begin
      failures++; $display("FAIL full_flash_pattern got=%b exp=1010", pat);
    end
    checks++;
    if (served !== 8'd1 || walk !== 1'b0 || dont_walk !== 1'b1) begin
      failures++; $display("FAIL full_served got=%0d walk=%b dw=%b exp=1/0/1", served, walk, dont_walk);
    end
    set_l(3'b110);
    tick();
    checks++;
    if (got !== exp_vec()) begin
      failures++; $display("FAIL full_leave_clear got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_abort();
    do_reset();
    request();
    for (int i = 0; i < 5 && !walk; i++) tick();
    checks++;
    if (walk !== 1'b1) begin
      failures++; $display("FAIL abort_walk_timeout got=%b exp=1", walk);
    end
    repeat (2) tick();
    set_l(3'b110);
    tick();
    checks++;
    if (walk !== 1'b0 || dont_walk !== 1'b1 || served !== 8'd0 || err !== 1'b0 || got !== exp_vec()) begin
      failures++; $display("FAIL abort got=%h exp=%h", got, exp_vec());
    end
    set_l(3'b001);
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    request();
    for (int i = 0; i < 5 && !walk; i++) tick();
    checks++;
    if (walk !== 1'b1) begin
      failures++; $display("FAIL illegal_walk_timeout got=%b exp=1", walk);
    end
    set_l(3'b111);
    tick();
    checks++;
    if (err !== 1'b1 || walk !== 1'b0 || dont_walk !== 1'b1 || got !== exp_vec()) begin
      failures++; $display("FAIL illegal_hit got=%h exp=%h", got, exp_vec());
    end
    set_l(3'b100);
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (err !== 1'b1 || walk !== 1'b0 || got !== exp_vec()) begin
        failures++; $display("FAIL illegal_hold cycle=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    set_l(3'b110);
    tick();
    checks++;
    if (err !== 1'b1 || got !== exp_vec()) begin
      failures++; $display("FAIL illegal_sticky got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_rerequest();
    bit walked = 0;
    do_reset();
    request();
    for (int i = 0; i < 5 && !walk; i++) tick();
    for (int i = 0; i < 12 && walk; i++) tick();
    checks++;
    if (walk !== 1'b0 || dont_walk !== 1'b1 || served !== 8'd0) begin
      failures++; $display("FAIL rereq_flash_timeout walk=%b dw=%b served=%0d exp=0/1/0", walk, dont_walk, served);
    end
    button = 1'b1;
    tick();
    button = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wait_lamp !== 1'b1 || got !== exp_vec()) begin
        failures++; $display("FAIL rereq_wait cycle=%0d got=%h exp=%h", i, got, exp_vec());
      end
      tick();
    end
    checks++;
    if (served !== 8'd1 || wait_lamp !== 1'b1 || walk !== 1'b0) begin
      failures++; $display("FAIL rereq_first served=%0d wait=%b exp=1/1", served, wait_lamp);
    end
    set_l(3'b110); tick();
    set_l(3'b001); tick();
    set_l(3'b010); tick();
    set_l(3'b100);
    for (int i = 0; i < 30 && served !== 8'd2; i++) begin
      tick();
      if (walk) walked = 1;
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL rereq_model cycle=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    checks++;
    if (served !== 8'd2 || !walked) begin
      failures++; $display("FAIL rereq_second served=%0d walked=%0d exp=2/1", served, walked);
    end
  endtask

  task automatic test_wrap();
    int wexp[5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      request();
      repeat (16) tick();
      set_l(3'b110);
      tick();
      checks++;
      if (served_w !== 2'(wexp[k]) || served !== 8'(k + 1)) begin
        failures++; $display("FAIL wrap k=%0d got=%0d/%0d exp=%0d/%0d", k, served_w, served, wexp[k], k + 1);
      end
    end
  endtask

  task automatic test_mid_walk_reset();
    do_reset();
    request();
    for (int i = 0; i < 5 && !walk; i++) tick();
    repeat (2) tick();
    checks++;
    if (walk !== 1'b1) begin
      failures++; $display("FAIL midrst_walk got=%b exp=1", walk);
    end
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      failures++; $display("FAIL midrst_async got=%h exp=%h", got, exp_vec());
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0] codes[4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 399) != 0;
      button = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 99) < 8)
        set_l($urandom_range(0, 199) == 0 ? 3'($urandom) : codes[$urandom_range(0, 3)]);
      tick();
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL random cycle=%0d got=%h exp=%h", i, got, exp_vec());
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_service();
    test_abort();
    test_illegal();
    test_rerequest();
    test_wrap();
    test_mid_walk_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ped_crossing.md
Name: ped_crossing

Overview:
- Pedestrian crossing controller that sits directly downstream of the traffic light sequencer `light`.
- Consumes its red/amber/green outputs plus a push button, and drives the walk, don't-walk and wait lamps.
- Only grants walk while the vehicle light is red-only, and forces a safe state on any illegal light code.
- Counts serviced crossings.

Parameters:
- WALK_CYCLES, 8, clock cycles the steady walk lamp is lit (legal range 1..255).
- FLASH_CYCLES, 4, clock cycles of flashing don't-walk after walk (legal range 1..255).
- CNT_W, 8, width of the serviced-crossing counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- red  input  1  vehicle red lamp from light.
- amber  input  1  vehicle amber lamp from light.
- green  input  1  vehicle green lamp from light.
- button  input  1  pedestrian request, level, synchronous to clk.
- walk  output  1  green-man lamp.
- dont_walk  output  1  red-man lamp; toggles during flash phase.
- wait_lamp  output  1  "WAIT" indicator; request latched and not yet served.
- err  output  1  sticky illegal-light-code flag.
- served  output  CNT_W  number of completed walk phases, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - walk=0, dont_walk=1, wait_lamp=0, err=0, served=0.
  - Request latch and down-counter are cleared.
- Light code L={red,amber,green}. Legal codes are 100, 110, 001, 010; all others are illegal.
- Request latch:
  - Set on any cycle with button=1, in any state.
  - Cleared on entry to WALK.
  - wait_lamp equals the latch, registered (visible one cycle after the press).
- States:
  - IDLE:
    - Latch set -> WAITING.
  - WAITING:
    - L==100 -> WALK; counter loads WALK_CYCLES-1.
    - Otherwise stay.
  - WALK:
    - walk=1, dont_walk=0.
    - Counter decrements each cycle.
    - At 0 -> FLASH; counter loads FLASH_CYCLES-1.
  - FLASH:
    - walk=0, dont_walk toggles every cycle; first FLASH cycle dont_walk=1.
    - Counter at 0 -> CLEAR; served increments.
  - CLEAR:
    - walk=0, dont_walk=1.
    - Wait for L!=100 (red phase ended).
    - Then -> WAITING if latch set, else IDLE.
- Outputs are registered. A transition decided at edge n shows its outputs after edge n.
- Abort: in WALK or FLASH, if L!=100 -> CLEAR next edge.
  - walk=0, dont_walk=1.
  - served is NOT incremented.
- Illegal code on any cycle:
  - err<=1 (sticky until reset).
  - State -> CLEAR, walk=0, dont_walk=1.
  - Illegal code takes priority over every other transition.
- A button press during WALK/FLASH/CLEAR re-arms the latch. That request is served in the next red phase, never the current one.
- Simultaneous button and L==100 in IDLE: latch sets this edge, WAITING next edge, WALK the edge after. So walk is asserted no earlier than 2 edges after the press.
- served wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-WALK returns immediately to the reset values above.

Decomposition:
- Shared package `ped_pkg`:
  - state enum: IDLE, WAITING, WALK, FLASH, CLEAR.
  - light-code constants: L_RED=3'b100, L_REDAMB=3'b110, L_GREEN=3'b001, L_AMBER=3'b010.
  - function `legal_code`.
- One natural sub-module, `phase_timer`: loadable down-counter with load value, enable and zero flag. It serves both the WALK and FLASH durations.

Test Plan:
- Reset and defaults:
  - Stimulus: hold rst=0 for 3 cycles with L=100, button=0.
  - Response: walk=0, dont_walk=1, wait_lamp=0, err=0, served=0; stays IDLE after release.
- Full service:
  - Stimulus: L=001; button pulse 1 cycle; then L=100 for 20 cycles.
  - Response: wait_lamp=1 until WALK entry.
  - Response: walk=1 for exactly 8 cycles.
  - Response: dont_walk pattern over the FLASH phase is 1,0,1,0.
  - Response: served=1; then CLEAR until L changes.
- Abort:
  - Stimulus: request served, L=100; switch L to 110 on the 3rd WALK cycle.
  - Response: walk=0 next cycle, dont_walk=1, served stays 0, err=0.
- Illegal code:
  - Stimulus: during WALK drive L=111 for 1 cycle, then L=100.
  - Response: err=1 and remains 1; walk=0; no new WALK without a fresh red phase.
- Re-request:
  - Stimulus: button pressed during FLASH.
  - Response: wait_lamp=1 through CLEAR.
  - Response: after L goes 110 -> 001 -> 010 -> 100, a second walk occurs and served=2.
- Wrap:
  - Stimulus: CNT_W=2; complete 5 full services.
  - Response: served sequence 1,2,3,0,1.
